// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
package spi_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    STORE
  } seq_state_t;

  // Slave-id width; a single slave still gets one bit so ports never collapse.
  function automatic int unsigned calc_sid_w(input int unsigned num_cs);
    if (num_cs > 32'd1) return $clog2(num_cs);
    return 32'd1;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push ignored when full, pop ignored when empty.
module spi_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign level  = r_wr_ptr - r_rd_ptr;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Queues SPI commands, launches them one at a time to the SPI master and queues tagged responses.
// Optional per-transaction watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_txn_sequencer
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter  int unsigned NUM_CS         = 1,
  parameter  int unsigned FIFO_DEPTH     = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned SID_W          = calc_sid_w(NUM_CS),
  localparam int unsigned LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [SID_W-1:0]      cmd_slave,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [SID_W-1:0]      rsp_slave,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic [SID_W-1:0]      spi_slave_id,
  input  logic                  spi_ready,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  output logic                  busy,
  output logic [LVL_W-1:0]      cmd_level,
  output logic [LVL_W-1:0]      rsp_level,
  output logic                  err_timeout
);

  localparam int unsigned ENT_W = DATA_WIDTH + SID_W;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("spi_txn_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  seq_state_t             r_state;
  seq_state_t             w_next;
  logic                   r_spi_start;
  logic                   r_busy;
  logic [DATA_WIDTH-1:0]  r_tx_data;
  logic [SID_W-1:0]       r_slave_id;
  logic                   w_cmd_full;
  logic                   w_cmd_empty;
  logic                   w_rsp_full;
  logic                   w_rsp_empty;
  logic                   w_cmd_push;
  logic                   w_cmd_pop;
  logic                   w_rsp_push;
  logic                   w_rsp_pop;
  logic                   w_tmo;
  logic [ENT_W-1:0]       w_cmd_head;
  logic [ENT_W-1:0]       w_rsp_head;

  assign w_cmd_push = cmd_valid & ~w_cmd_full;
  assign w_rsp_pop  = rsp_ready & ~w_rsp_empty;

  spi_sync_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_cmd_push),
    .pop   (w_cmd_pop),
    .din   ({cmd_data, cmd_slave}),
    .dout  (w_cmd_head),
    .full  (w_cmd_full),
    .empty (w_cmd_empty),
    .level (cmd_level)
  );

  spi_sync_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rsp_push),
    .pop   (w_rsp_pop),
    .din   ({spi_rx_data, r_slave_id}),
    .dout  (w_rsp_head),
    .full  (w_rsp_full),
    .empty (w_rsp_empty),
    .level (rsp_level)
  );

  assign cmd_ready               = ~w_cmd_full;
  assign rsp_valid               = ~w_rsp_empty;
  assign {rsp_data, rsp_slave}   = w_rsp_head;
  assign spi_start               = r_spi_start;
  assign spi_tx_data             = r_tx_data;
  assign spi_slave_id            = r_slave_id;
  assign busy                    = r_busy;

  // Launch only with a free rsp slot, so the STORE push can never be refused.
  always_comb begin
    w_next     = r_state;
    w_cmd_pop  = 1'b0;
    w_rsp_push = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_cmd_empty && !w_rsp_full && spi_ready) begin
          w_next    = LAUNCH;
          w_cmd_pop = 1'b1;
        end
      end
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: if (!spi_ready) w_next = WAIT_DONE;
      WAIT_DONE: if (spi_ready)  w_next = STORE;
      STORE: begin
        w_rsp_push = 1'b1;
        w_next     = IDLE;
      end
      default:   w_next = IDLE;
    endcase
    if (w_tmo) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_spi_start <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_data   <= '0;
      r_slave_id  <= '0;
    end else begin
      r_state     <= w_next;
      r_spi_start <= (w_next == LAUNCH);
      r_busy      <= (w_next != IDLE);
      if (w_cmd_pop) {r_tx_data, r_slave_id} <= w_cmd_head;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err_timeout;
  logic             w_in_wait;

  assign w_in_wait   = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
  assign w_tmo       = w_in_wait && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err_timeout;

  // Counts wait cycles of the current transaction; cleared whenever outside the wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_tmo;
      if (w_in_wait && !w_tmo) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                     r_tmo_cnt <= '0;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a behavioural SPI master (rx = tx ^ 0x99).
module tb_spi_txn_sequencer;

  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 2;
  localparam int unsigned LW  = 3;

  localparam logic [7:0] T2_TX [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  localparam logic [7:0] T2_RX [4] = '{8'h89, 8'hB8, 8'hAB, 8'hDA};
  localparam logic [1:0] T2_SL [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [7:0] T3_TX [6] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
  localparam logic [7:0] T3_RX [6] = '{8'h39, 8'h28, 8'h5B, 8'h4A, 8'h7D, 8'h6C};
  localparam logic [1:0] T3_SL [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1};

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_slave;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [SW-1:0] rsp_slave;
  logic          spi_start;
  logic [DW-1:0] spi_tx_data;
  logic [SW-1:0] spi_slave_id;
  logic          spi_ready;
  logic [DW-1:0] spi_rx_data;
  logic          busy;
  logic [LW-1:0] cmd_level;
  logic [LW-1:0] rsp_level;
  logic          err_timeout;

  int n_checks    = 0;
  int n_fail      = 0;
  int n_starts    = 0;
  int overlap_cnt = 0;
  int model_hold  = 40;
  logic hold_low  = 1'b0;
  logic prev_start = 1'b0;

  spi_txn_sequencer #(
    .DATA_WIDTH(8), .NUM_CS(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_slave(cmd_slave),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_slave_id(spi_slave_id),
    .spi_ready(spi_ready), .spi_rx_data(spi_rx_data),
    .busy(busy), .cmd_level(cmd_level), .rsp_level(rsp_level), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // SPI master model: ready drops 2 cycles after start, rises model_hold cycles later.
  initial begin : spi_model
    logic [DW-1:0] tx;
    spi_ready   = 1'b1;
    spi_rx_data = '0;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        tx = spi_tx_data;
        @(negedge clk);
        @(negedge clk);
        spi_ready = 1'b0;
        repeat (model_hold) @(negedge clk);
        spi_rx_data = tx ^ 8'h99;
        spi_ready   = 1'b1;
      end else begin
        spi_ready = ~hold_low;
      end
    end
  end

  // Start monitor: a launch must be single-cycle and only toward a ready master.
  always @(negedge clk) begin
    if (spi_start === 1'b1) begin
      n_starts = n_starts + 1;
      if (spi_ready !== 1'b1 || prev_start === 1'b1) overlap_cnt = overlap_cnt + 1;
    end
    prev_start = spi_start;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] d, input logic [1:0] s);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin tick(); n++; end
    check("push cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_slave = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp(input logic [7:0] ed, input logic [1:0] es, input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin tick(); n++; end
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_data"},  32'(rsp_data),  32'(ed));
    check({tag, " rsp_slave"}, 32'(rsp_slave), 32'(es));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_ready(input logic lvl, input int limit, input string tag);
    int n = 0;
    while (spi_ready !== lvl && n < limit) begin tick(); n++; end
    check(tag, 32'(spi_ready), 32'(lvl));
  endtask

  initial begin : stimulus
    int base;
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_slave = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst cmd_ready",    32'(cmd_ready),    32'd1);
    check("rst rsp_valid",    32'(rsp_valid),    32'd0);
    check("rst spi_start",    32'(spi_start),    32'd0);
    check("rst busy",         32'(busy),         32'd0);
    check("rst err_timeout",  32'(err_timeout),  32'd0);
    check("rst spi_tx_data",  32'(spi_tx_data),  32'd0);
    check("rst spi_slave_id", 32'(spi_slave_id), 32'd0);
    check("rst cmd_level",    32'(cmd_level),    32'd0);
    check("rst rsp_level",    32'(rsp_level),    32'd0);
    rst = 1'b0;
    tick();

    // Single command 0xA5 to slave 0, 40-cycle master transfer
    model_hold = 40;
    push_cmd(8'hA5, 2'd0);
    check("t1 cmd_level after push", 32'(cmd_level), 32'd1);
    check("t1 start not yet",        32'(spi_start), 32'd0);
    tick();
    check("t1 spi_start",      32'(spi_start),    32'd1);
    check("t1 busy",           32'(busy),         32'd1);
    check("t1 cmd_level pop",  32'(cmd_level),    32'd0);
    check("t1 spi_tx_data",    32'(spi_tx_data),  32'h0000_00A5);
    check("t1 spi_slave_id",   32'(spi_slave_id), 32'd0);
    tick();
    check("t1 start one-cycle", 32'(spi_start), 32'd0);
    wait_ready(1'b0, 10, "t1 ready drop");
    wait_ready(1'b1, 60, "t1 ready rise");
    check("t1 tx held",        32'(spi_tx_data), 32'h0000_00A5);
    check("t1 rsp not yet",    32'(rsp_valid),   32'd0);
    check("t1 busy in store",  32'(busy),        32'd1);
    tick();
    check("t1 rsp_valid",      32'(rsp_valid),   32'd1);
    check("t1 rsp_level",      32'(rsp_level),   32'd1);
    check("t1 busy idle",      32'(busy),        32'd0);
    pop_rsp(8'h3C, 2'd0, "t1");
    check("t1 n_starts",       32'(n_starts),    32'd1);

    // Four commands queued while the master is held busy; FIFO fills
    model_hold = 6;
    base = n_starts;
    hold_low = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) push_cmd(T2_TX[i], T2_SL[i]);
    check("t2 cmd_ready full",  32'(cmd_ready), 32'd0);
    check("t2 cmd_level full",  32'(cmd_level), 32'd4);
    check("t2 no launch",       32'(n_starts - base), 32'd0);
    cmd_valid = 1'b1;
    cmd_data  = 8'hEE;
    cmd_slave = 2'd2;
    tick();
    cmd_valid = 1'b0;
    check("t2 push to full",    32'(cmd_level), 32'd4);
    hold_low = 1'b0;
    for (int i = 0; i < 4; i++) pop_rsp(T2_RX[i], T2_SL[i], $sformatf("t2[%0d]", i));
    repeat (20) tick();
    check("t2 no extra rsp",    32'(rsp_valid), 32'd0);
    check("t2 cmd drained",     32'(cmd_level), 32'd0);
    check("t2 n_starts",        32'(n_starts - base), 32'd4);

    // Six commands with consumer stalled: four launch, then IDLE stall
    model_hold = 4;
    base = n_starts;
    for (int i = 0; i < 6; i++) push_cmd(T3_TX[i], T3_SL[i]);
    repeat (80) tick();
    check("t3 launches stalled", 32'(n_starts - base), 32'd4);
    check("t3 rsp_level full",   32'(rsp_level), 32'd4);
    check("t3 cmd_level left",   32'(cmd_level), 32'd2);
    check("t3 busy idle",        32'(busy),      32'd0);
    check("t3 master ready",     32'(spi_ready), 32'd1);
    for (int i = 0; i < 6; i++) pop_rsp(T3_RX[i], T3_SL[i], $sformatf("t3[%0d]", i));
    repeat (20) tick();
    check("t3 n_starts",         32'(n_starts - base), 32'd6);
    check("t3 rsp empty",        32'(rsp_level), 32'd0);

    // Reset during WAIT_DONE discards the transfer and the queued command
    model_hold = 30;
    base = n_starts;
    push_cmd(8'h11, 2'd3);
    wait_ready(1'b0, 10, "t4 ready drop");
    push_cmd(8'h22, 2'd1);
    tick();
    check("t4 busy in wait", 32'(busy),      32'd1);
    check("t4 cmd queued",   32'(cmd_level), 32'd1);
    rst = 1'b1;
    tick();
    check("t4 rst busy",      32'(busy),      32'd0);
    check("t4 rst rsp_level", 32'(rsp_level), 32'd0);
    check("t4 rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("t4 rst cmd_level", 32'(cmd_level), 32'd0);
    rst = 1'b0;
    wait_ready(1'b1, 60, "t4 stale ready rise");
    repeat (4) tick();
    check("t4 stale rsp_level", 32'(rsp_level), 32'd0);
    check("t4 stale rsp_valid", 32'(rsp_valid), 32'd0);
    check("t4 no relaunch",     32'(n_starts - base), 32'd1);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Master stuck low: timeout after 16 wait cycles, nothing pushed
    model_hold = 60;
    push_cmd(8'h55, 2'd1);
    n = 0;
    while (spi_start !== 1'b1 && n < 10) begin tick(); n++; end
    check("t5 start seen", 32'(spi_start), 32'd1);
    n = 0;
    while (err_timeout !== 1'b1 && n < 40) begin tick(); n++; end
    check("t5 err cycle",   32'(n),           32'd17);
    check("t5 err busy",    32'(busy),        32'd0);
    tick();
    check("t5 err one-cycle", 32'(err_timeout), 32'd0);
    wait_ready(1'b1, 80, "t5 late ready");
    repeat (4) tick();
    check("t5 rsp_level",   32'(rsp_level), 32'd0);
    check("t5 cmd_level",   32'(cmd_level), 32'd0);
`else
    n = 0;
    check("t5 err tied low", 32'(err_timeout), 32'd0);
`endif

    check("start overlap", 32'(overlap_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
